c499_resp_misr: RTL and testbench
=================================

C499_RESP_MISR -- requirements
Module: c499_resp_misr

Interface
REQ-001 SHALL have parameter SEED, default 32'hFFFF_FFFF, the MISR initial signature.
REQ-002 SHALL have parameter POLY, default 32'h0040_0007 (x^32+x^22+x^2+x+1), the feedback taps.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a compaction run.
REQ-006 SHALL have port num_vec, input, 16, the number of response vectors per run, sampled on an accepted start.
REQ-007 SHALL have port resp_valid, input, 1, qualifying resp this cycle.
REQ-008 SHALL have port resp, input, 32, the c499 output vector, out[0] on bit 0.
REQ-009 SHALL have port golden, input, 32, the expected signature.
REQ-010 SHALL have port busy, output, 1, high in RUN.
REQ-011 SHALL have port done, output, 1, high in DONE.
REQ-012 SHALL have port sig, output, 32, the current signature.
REQ-013 SHALL have port vec_cnt, output, 16, the number of vectors accepted in the current run.
REQ-014 SHALL have port match, output, 1, asserted when sig==golden in DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE, with IDLE as the reset state.
REQ-016 SHALL, on start in IDLE or DONE, load sig=SEED, clear vec_cnt, capture num_vec, and go to RUN next cycle, or straight to DONE if num_vec==0.
REQ-017 SHALL ignore start while in RUN.
REQ-018 SHALL, in RUN with resp_valid=1, update sig <= {sig[30:0],0} ^ (sig[31] ? POLY : 0) ^ resp and increment vec_cnt, both in the same cycle.
REQ-019 SHALL hold sig and vec_cnt in RUN when resp_valid=0 (gaps allowed).
REQ-020 SHALL, on acceptance of the last vector (vec_cnt+1==captured num_vec), enter DONE on the next edge, with a final sig visible together with done.
REQ-021 SHALL ignore resp_valid in IDLE and DONE, leaving sig unchanged.
REQ-022 SHALL hold done, sig and match in DONE until the next start or rst.
REQ-023 SHALL drive all outputs directly from registers; match SHALL be registered on DONE entry.

Reset
REQ-024 SHALL, on rst=1 at a clk edge in any state including mid-run, set state=IDLE, sig=SEED, vec_cnt=0, busy=0, done=0, match=0.
REQ-025 SHALL give rst priority over start and resp_valid in the same cycle.

Configuration
REQ-026 SHALL, with macro C499_MISR_GOLDEN_CMP_EN defined, compute match per REQ-014 and REQ-023.
REQ-027 SHALL, without C499_MISR_GOLDEN_CMP_EN, leave golden unused and tie match to 0.

Structure
REQ-028 SHALL place the state enum, the default POLY and SEED constants, and the width constants (32 response bits, 16 count bits) in shared package c499_pkg.
REQ-029 SHALL place the one-step signature update in sub-module c499_misr_step (purely combinational: sig, resp, POLY -> next sig).

Verification
REQ-030 SHALL verify: rst, then start with num_vec=1, one resp=0 -> done=1 after 1 cycle, sig=32'hFFBF_FFF9, vec_cnt=1.
REQ-031 SHALL verify: start with num_vec=0 -> done=1 next cycle, sig=32'hFFFF_FFFF, and busy never asserted.
REQ-032 SHALL verify: num_vec=4 with resp_valid gaps of 0-3 cycles -> vec_cnt=4 and sig identical to the gap-free reference-model result.
REQ-033 SHALL verify: a start pulse mid-run is ignored, and rst on vector 2 of 4 -> IDLE, sig=SEED, done=0.
REQ-034 SHALL verify: with the macro defined, golden equal to the model signature gives match=1, and golden with bit 0 flipped gives match=0; without the macro, match=0 always.
REQ-035 SHALL verify: 1000 random 41-bit c499 stimuli, with responses from the correct 32-bit key applied to the unlocked c499 -> sig equals the model signature.

Source files
------------

// File: rtl/c499_pkg.sv
// Shared definitions for the c499 response MISR: FSM states, default
// signature seed / feedback polynomial, and datapath widths.
package c499_pkg;

    localparam int RESP_W = 32;   // c499 output vector width
    localparam int CNT_W  = 16;   // response vector counter width

    localparam logic [RESP_W-1:0] DEFAULT_SEED = 32'hFFFF_FFFF;
    localparam logic [RESP_W-1:0] DEFAULT_POLY = 32'h0040_0007;  // x^32+x^22+x^2+x+1

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/c499_misr_step.sv
// One combinational MISR step: shift the signature left by one, fold the
// outgoing MSB back through the feedback taps, and XOR in the response.
module c499_misr_step
    import c499_pkg::*;
#(
    parameter logic [RESP_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic [RESP_W-1:0] sig_i,
    input  logic [RESP_W-1:0] resp_i,
    output logic [RESP_W-1:0] sig_o
);

    logic fb;
    assign fb = sig_i[RESP_W-1];

    // Per-bit next signature: shifted-in bit, tap feedback, response bit.
    for (genvar gi = 0; gi < RESP_W; gi++) begin : g_bit
        if (gi == 0) begin : g_lsb
            assign sig_o[gi] = (fb & POLY[gi]) ^ resp_i[gi];
        end else begin : g_upper
            assign sig_o[gi] = sig_i[gi-1] ^ (fb & POLY[gi]) ^ resp_i[gi];
        end
    end

endmodule

// File: rtl/c499_resp_misr.sv
// Response compactor for c499: folds num_vec qualified response vectors into
// a 32-bit MISR signature. Optional golden compare is built only when the
// macro C499_MISR_GOLDEN_CMP_EN is defined; otherwise match is tied low.
module c499_resp_misr
    import c499_pkg::*;
#(
    parameter logic [RESP_W-1:0] SEED = DEFAULT_SEED,
    parameter logic [RESP_W-1:0] POLY = DEFAULT_POLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    input  logic [RESP_W-1:0] golden,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] sig,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic              match
);

    state_e            state_q, state_d;
    logic [RESP_W-1:0] sig_q,   sig_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [CNT_W-1:0]  num_q,   num_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              match_q, match_d;

    logic [RESP_W-1:0] step_sig;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cmp_seed;   // golden check for an empty run
    logic              cmp_step;   // golden check for the final vector

    assign cnt_inc = cnt_q + CNT_W'(1);

    c499_misr_step #(
        .POLY (POLY)
    ) u_step (
        .sig_i  (sig_q),
        .resp_i (resp),
        .sig_o  (step_sig)
    );

`ifdef C499_MISR_GOLDEN_CMP_EN
    assign cmp_seed = (SEED == golden);
    assign cmp_step = (step_sig == golden);
`else
    logic unused_golden;
    assign unused_golden = ^golden;
    assign cmp_seed      = 1'b0;
    assign cmp_step      = 1'b0;
`endif

    // Next-state and datapath decisions; match is only ever loaded on the
    // transition into DONE so it stays frozen while DONE holds.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        match_d = match_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    num_d   = num_vec;
                    match_d = 1'b0;
                    if (num_vec == '0) begin
                        state_d = ST_DONE;
                        match_d = cmp_seed;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (resp_valid) begin
                    sig_d = step_sig;
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = ST_DONE;
                        match_d = cmp_step;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            num_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sig     = sig_q;
    assign vec_cnt = cnt_q;
    assign match   = match_q;

endmodule

// File: tb/tb_c499_resp_misr.sv
// Self-checking bench for c499_resp_misr. Expected signatures come from a
// polynomial-arithmetic MISR model and a behavioural c499 (32-bit SEC) model.
module tb_c499_resp_misr;
    import c499_pkg::*;

    localparam logic [31:0] SEED   = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY   = 32'h0040_0007;
    localparam logic [31:0] KEY_OK = 32'hA5C3_9E17;  // correct unlock key

`ifdef C499_MISR_GOLDEN_CMP_EN
    localparam logic CMP_EN = 1'b1;
`else
    localparam logic CMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vec = '0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp = '0;
    logic [31:0] golden = '0;
    logic        busy, done, match;
    logic [31:0] sig;
    logic [15:0] vec_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    c499_resp_misr #(
        .SEED (SEED),
        .POLY (POLY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .resp_valid (resp_valid),
        .resp       (resp),
        .golden     (golden),
        .busy       (busy),
        .done       (done),
        .sig        (sig),
        .vec_cnt    (vec_cnt),
        .match      (match)
    );

    // ---------------- reference models ----------------
    // Signature update as GF(2) polynomial arithmetic: sig*x mod P, plus resp.
    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] r);
        logic [32:0] prod;
        prod = {s, 1'b0};
        if (prod[32]) prod = prod ^ {1'b1, POLY};
        return prod[31:0] ^ r;
    endfunction

    // Behavioural c499: 32 data bits, 8 check bits, enable r. Each data bit
    // owns a distinct 8-bit column code; a syndrome equal to a column flips
    // that bit. Key bits differing from KEY_OK corrupt the outputs.
    function automatic logic [31:0] c499_ref(input logic [40:0] x, input logic [31:0] key);
        logic [31:0] id;
        logic [7:0]  syn;
        logic [31:0] out;
        id  = x[31:0];
        syn = x[39:32];
        for (int i = 0; i < 32; i++)
            if (id[i]) syn = syn ^ {3'b011, 5'(i)};
        if (!x[40]) syn = 8'h00;
        for (int i = 0; i < 32; i++)
            out[i] = id[i] ^ (syn == {3'b011, 5'(i)});
        return out ^ (key ^ KEY_OK);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] n);
        start   = 1'b1;
        num_vec = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input logic [31:0] r);
        resp_valid = 1'b1;
        resp       = r;
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk(name, done, 1);
    endtask

    typedef struct {
        logic [15:0] n;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] exp_sig;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [5];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] exp_sig;
        logic [31:0] held;
        logic [31:0] rv [4];
        logic [63:0] w;
        logic [40:0] x;

        tbl[0] = '{16'd1, 32'h0000_0000, 32'h0, 32'hFFBF_FFF9, 16'd1};
        tbl[1] = '{16'd1, 32'hFFFF_FFFF, 32'h0, 32'h0040_0006, 16'd1};
        tbl[2] = '{16'd2, 32'h0000_0000, 32'h0, 32'hFF3F_FFF5, 16'd2};
        tbl[3] = '{16'd1, 32'h0000_0001, 32'h0, 32'hFFBF_FFF8, 16'd1};
        tbl[4] = '{16'd0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 16'd0};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sig", sig, SEED);
        chk("rst_cnt", vec_cnt, 0);
        chk("rst_match", match, 0);
        $display("reset: busy=%b done=%b sig=%h", busy, done, sig);

        // Single zero vector straight after reset
        start_run(16'd1);
        chk("one_busy", busy, 1);
        send(32'h0);
        chk("one_done", done, 1);
        chk("one_sig", sig, 32'hFFBF_FFF9);
        chk("one_cnt", vec_cnt, 1);
        $display("run one: sig=%h cnt=%0d", sig, vec_cnt);

        // Table runs, each restarting from DONE
        for (int t = 0; t < 5; t++) begin
            exp_sig = SEED;
            for (int k = 0; k < int'(tbl[t].n); k++)
                exp_sig = model_step(exp_sig, (k == 0) ? tbl[t].r0 : tbl[t].r1);
            chk($sformatf("tbl%0d_model", t), exp_sig, tbl[t].exp_sig);
            golden = exp_sig;
            start_run(tbl[t].n);
            chk($sformatf("tbl%0d_busy", t), busy, (tbl[t].n != 0) ? 1 : 0);
            for (int k = 0; k < int'(tbl[t].n); k++) begin
                chk($sformatf("tbl%0d_done_early", t), done, 0);
                send((k == 0) ? tbl[t].r0 : tbl[t].r1);
            end
            chk($sformatf("tbl%0d_done", t), done, 1);
            chk($sformatf("tbl%0d_busy_end", t), busy, 0);
            chk($sformatf("tbl%0d_sig", t), sig, tbl[t].exp_sig);
            chk($sformatf("tbl%0d_cnt", t), vec_cnt, tbl[t].exp_cnt);
            chk($sformatf("tbl%0d_match", t), match, CMP_EN);
            $display("table %0d: n=%0d sig=%h cnt=%0d match=%b", t, tbl[t].n, sig, vec_cnt, match);
        end

        // resp_valid in DONE is ignored and DONE holds
        held = sig;
        golden = ~golden;
        send($urandom);
        tick();
        chk("done_ign_sig", sig, held);
        chk("done_hold", done, 1);
        chk("done_ign_cnt", vec_cnt, 0);
        chk("done_match_hold", match, CMP_EN);
        $display("done hold: sig=%h", sig);

        // Gapped runs of four vectors versus gap-free model
        for (int trial = 0; trial < 4; trial++) begin
            exp_sig = SEED;
            for (int k = 0; k < 4; k++) begin
                rv[k]   = $urandom;
                exp_sig = model_step(exp_sig, rv[k]);
            end
            golden = (trial % 2 == 1) ? (exp_sig ^ 32'h1) : exp_sig;
            start_run(16'd4);
            for (int k = 0; k < 4; k++) begin
                int gap;
                gap  = $urandom_range(0, 3);
                held = sig;
                for (int g = 0; g < gap; g++) tick();
                if (gap > 0) chk($sformatf("gap%0d_hold", trial), sig, held);
                send(rv[k]);
            end
            wait_done($sformatf("gap%0d_done", trial), 4);
            chk($sformatf("gap%0d_cnt", trial), vec_cnt, 4);
            chk($sformatf("gap%0d_sig", trial), sig, exp_sig);
            chk($sformatf("gap%0d_match", trial), match, (trial % 2 == 1) ? 0 : CMP_EN);
            $display("gapped %0d: sig=%h match=%b", trial, sig, match);
        end

        // Start pulse mid-run is ignored
        exp_sig = SEED;
        for (int k = 0; k < 3; k++) begin
            rv[k]   = $urandom;
            exp_sig = model_step(exp_sig, rv[k]);
        end
        start_run(16'd3);
        send(rv[0]);
        start   = 1'b1;
        num_vec = 16'd7;
        tick();
        start   = 1'b0;
        chk("midstart_busy", busy, 1);
        chk("midstart_cnt", vec_cnt, 1);
        send(rv[1]);
        send(rv[2]);
        chk("midstart_done", done, 1);
        chk("midstart_cnt_end", vec_cnt, 3);
        chk("midstart_sig", sig, exp_sig);
        $display("mid-run start: sig=%h cnt=%0d", sig, vec_cnt);

        // Reset on vector 2 of 4, together with start and resp_valid
        golden = SEED;
        start_run(16'd4);
        send($urandom);
        rst        = 1'b1;
        start      = 1'b1;
        num_vec    = 16'd0;
        resp_valid = 1'b1;
        resp       = $urandom;
        tick();
        rst        = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_sig", sig, SEED);
        chk("midrst_cnt", vec_cnt, 0);
        chk("midrst_match", match, 0);
        tick();
        chk("midrst_idle_done", done, 0);
        $display("mid-run reset: busy=%b done=%b sig=%h", busy, done, sig);

        // 1000 c499 responses under the correct key
        begin
            logic [31:0] resp_q [$];
            exp_sig = SEED;
            for (int k = 0; k < 1000; k++) begin
                w = {$urandom, $urandom};
                x = w[40:0];
                resp_q.push_back(c499_ref(x, KEY_OK));
                exp_sig = model_step(exp_sig, resp_q[k]);
            end
            golden = exp_sig;
            start_run(16'd1000);
            for (int k = 0; k < 1000; k++) begin
                if ($urandom_range(0, 7) == 0) tick();
                send(resp_q[k]);
            end
            wait_done("c499_done", 4);
            chk("c499_cnt", vec_cnt, 1000);
            chk("c499_sig", sig, exp_sig);
            chk("c499_match", match, CMP_EN);
            $display("c499 run: sig=%h cnt=%0d match=%b", sig, vec_cnt, match);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
